// File: rtl/writeback_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : writeback_stage
// Brief    : Final pipeline stage. Retires completed instructions, waits a
//            bounded time for load data and drives the register-file write
//            port plus the matching forwarding bus.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_stage #(
    parameter int LOAD_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        mem_valid,
    output logic        wb_ready,
    input  logic        mem_RegWrite,
    input  logic [2:0]  mem_rd,
    input  logic [1:0]  mem_ResultSrc,
    input  logic [7:0]  mem_alu_result,
    input  logic [7:0]  mem_pc_plus1,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    output logic        RegWrite,
    output logic [2:0]  write_reg,
    output logic [7:0]  write_data,
    output logic        fwd_valid,
    output logic [2:0]  fwd_rd,
    output logic [7:0]  fwd_data,
    output logic        load_err,
    output logic [15:0] retire_count
);

    localparam logic [1:0] c_SRC_LOAD = 2'b01;
    localparam logic [1:0] c_SRC_LINK = 2'b10;
    localparam logic [7:0] c_TCNT_LAST = 8'(LOAD_TIMEOUT - 1);

    typedef enum logic [0:0] {
        S_IDLE      = 1'b0,
        S_WAIT_LOAD = 1'b1
    } state_t;

    state_t      r_state;
    logic [7:0]  r_tcnt;
    logic [2:0]  r_rd;
    logic        r_regwrite;
    logic        r_wr_en;
    logic [2:0]  r_wr_reg;
    logic [7:0]  r_wr_data;
    logic        r_load_err;
    logic [15:0] r_retire;

    logic        w_accept;
    logic        w_is_load;
    logic [7:0]  w_sel_data;

    assign wb_ready  = (r_state == S_IDLE);
    assign w_accept  = mem_valid && wb_ready && !flush;
    assign w_is_load = (mem_ResultSrc == c_SRC_LOAD);

    // Reserved encoding 11 falls back to the ALU result.
    always_comb begin
        w_sel_data = mem_alu_result;
        case (mem_ResultSrc)
            c_SRC_LOAD: w_sel_data = load_data;
            c_SRC_LINK: w_sel_data = mem_pc_plus1;
            default:    w_sel_data = mem_alu_result;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_tcnt     <= 8'd0;
            r_rd       <= 3'd0;
            r_regwrite <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_reg   <= 3'd0;
            r_wr_data  <= 8'd0;
            r_load_err <= 1'b0;
            r_retire   <= 16'd0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (!w_is_load || load_valid) begin
                            r_wr_en   <= mem_RegWrite && (mem_rd != 3'd0);
                            r_wr_reg  <= mem_rd;
                            r_wr_data <= w_sel_data;
                            r_retire  <= r_retire + 16'd1;
                        end else begin
                            r_state    <= S_WAIT_LOAD;
                            r_tcnt     <= 8'd0;
                            r_rd       <= mem_rd;
                            r_regwrite <= mem_RegWrite;
                        end
                    end
                end
                S_WAIT_LOAD: begin
                    if (load_valid) begin
                        r_wr_en   <= r_regwrite && (r_rd != 3'd0);
                        r_wr_reg  <= r_rd;
                        r_wr_data <= load_data;
                        r_retire  <= r_retire + 16'd1;
                        r_state   <= S_IDLE;
                    end else if (r_tcnt == c_TCNT_LAST) begin
                        // Abandoned load: flag it, never write or retire.
                        r_load_err <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign RegWrite     = r_wr_en;
    assign write_reg    = r_wr_reg;
    assign write_data   = r_wr_data;
    assign fwd_valid    = r_wr_en;
    assign fwd_rd       = r_wr_reg;
    assign fwd_data     = r_wr_data;
    assign load_err     = r_load_err;
    assign retire_count = r_retire;

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_writeback_stage
// Brief    : Directed vector table plus hand-written load/timeout/reset/wrap
//            sequences for writeback_stage (LOAD_TIMEOUT = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush, mem_valid, mem_RegWrite, load_valid;
    logic [2:0]  mem_rd;
    logic [1:0]  mem_ResultSrc;
    logic [7:0]  mem_alu_result, mem_pc_plus1, load_data;
    logic        wb_ready, RegWrite, fwd_valid, load_err;
    logic [2:0]  write_reg, fwd_rd;
    logic [7:0]  write_data, fwd_data;
    logic [15:0] retire_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    writeback_stage #(.LOAD_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .flush(flush), .mem_valid(mem_valid),
        .wb_ready(wb_ready), .mem_RegWrite(mem_RegWrite), .mem_rd(mem_rd),
        .mem_ResultSrc(mem_ResultSrc), .mem_alu_result(mem_alu_result),
        .mem_pc_plus1(mem_pc_plus1), .load_valid(load_valid), .load_data(load_data),
        .RegWrite(RegWrite), .write_reg(write_reg), .write_data(write_data),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .load_err(load_err), .retire_count(retire_count)
    );

    typedef struct {
        logic        flush;
        logic        valid;
        logic        rw;
        logic [2:0]  rd;
        logic [1:0]  src;
        logic [7:0]  alu;
        logic [7:0]  pc;
        logic        lv;
        logic [7:0]  ld;
        logic        e_rw;
        logic [2:0]  e_reg;
        logic [7:0]  e_data;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic fl, input logic rw, input logic [2:0] rd,
                         input logic [1:0] src, input logic [7:0] alu, input logic [7:0] pc,
                         input logic lv, input logic [7:0] ld);
        mem_valid = v; flush = fl; mem_RegWrite = rw; mem_rd = rd; mem_ResultSrc = src;
        mem_alu_result = alu; mem_pc_plus1 = pc; load_valid = lv; load_data = ld;
    endtask

    task automatic chk_write(input string name, input logic [2:0] rd, input logic [7:0] d);
        chk({name, ".RegWrite"}, RegWrite, 1);
        chk({name, ".write_reg"}, write_reg, rd);
        chk({name, ".write_data"}, write_data, d);
        chk({name, ".fwd_valid"}, fwd_valid, 1);
        chk({name, ".fwd_rd"}, fwd_rd, rd);
        chk({name, ".fwd_data"}, fwd_data, d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          fl   v    rw   rd    src    alu    pc     lv   ld     e_rw e_reg e_data e_cnt
        vecs[0] = '{1'b0,1'b1,1'b1,3'd3,2'b00,8'h5A,8'h00,1'b0,8'h00,1'b1,3'd3,8'h5A,16'd1};
        vecs[1] = '{1'b0,1'b1,1'b1,3'd7,2'b10,8'h99,8'h21,1'b0,8'h00,1'b1,3'd7,8'h21,16'd2};
        vecs[2] = '{1'b0,1'b1,1'b1,3'd1,2'b11,8'h44,8'h10,1'b0,8'h00,1'b1,3'd1,8'h44,16'd3};
        vecs[3] = '{1'b0,1'b1,1'b1,3'd4,2'b01,8'h11,8'h00,1'b1,8'hB7,1'b1,3'd4,8'hB7,16'd4};
        vecs[4] = '{1'b0,1'b1,1'b1,3'd0,2'b00,8'hFF,8'h00,1'b0,8'h00,1'b0,3'd0,8'h00,16'd5};
        vecs[5] = '{1'b1,1'b1,1'b1,3'd5,2'b00,8'h12,8'h00,1'b0,8'h00,1'b0,3'd0,8'h00,16'd5};
        vecs[6] = '{1'b0,1'b1,1'b0,3'd6,2'b00,8'h34,8'h00,1'b0,8'h00,1'b0,3'd0,8'h00,16'd6};
        vecs[7] = '{1'b0,1'b0,1'b1,3'd6,2'b01,8'h00,8'h00,1'b1,8'hAB,1'b0,3'd0,8'h00,16'd6};
        vecs[8] = '{1'b0,1'b1,1'b1,3'd2,2'b00,8'h33,8'h00,1'b0,8'h00,1'b1,3'd2,8'h33,16'd7};
        vecs[9] = '{1'b0,1'b1,1'b1,3'd6,2'b00,8'h66,8'h00,1'b0,8'h00,1'b1,3'd6,8'h66,16'd8};

        reset = 1'b1;
        drive(0, 0, 0, 3'd0, 2'b00, 8'h00, 8'h00, 0, 8'h00);
        repeat (3) step();
        reset = 1'b0;
        chk("rst.RegWrite", RegWrite, 0);
        chk("rst.write_reg", write_reg, 0);
        chk("rst.write_data", write_data, 0);
        chk("rst.fwd", {fwd_valid, fwd_rd, fwd_data}, 0);
        chk("rst.load_err", load_err, 0);
        chk("rst.retire_count", retire_count, 0);
        chk("rst.wb_ready", wb_ready, 1);

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].valid, vecs[i].flush, vecs[i].rw, vecs[i].rd, vecs[i].src,
                  vecs[i].alu, vecs[i].pc, vecs[i].lv, vecs[i].ld);
            step();
            chk($sformatf("vec%0d.RegWrite", i), RegWrite, vecs[i].e_rw);
            chk($sformatf("vec%0d.fwd_valid", i), fwd_valid, vecs[i].e_rw);
            if (vecs[i].e_rw)
                chk_write($sformatf("vec%0d", i), vecs[i].e_reg, vecs[i].e_data);
            chk($sformatf("vec%0d.retire_count", i), retire_count, vecs[i].e_cnt);
            chk($sformatf("vec%0d.wb_ready", i), wb_ready, 1);
        end

        // Delayed load: load_valid arrives in the third wait cycle; a younger ALU op waits.
        drive(1, 0, 1, 3'd2, 2'b01, 8'h00, 8'h00, 0, 8'h00);
        step();
        chk("dl.w1.wb_ready", wb_ready, 0);
        chk("dl.w1.RegWrite", RegWrite, 0);
        drive(1, 0, 1, 3'd5, 2'b00, 8'h77, 8'h00, 0, 8'h00);
        step();
        chk("dl.w2.wb_ready", wb_ready, 0);
        chk("dl.w2.RegWrite", RegWrite, 0);
        step();
        load_valid = 1'b1; load_data = 8'hC3;
        chk("dl.w3.wb_ready", wb_ready, 0);
        chk("dl.w3.retire_count", retire_count, 8);
        step();
        load_valid = 1'b0;
        chk_write("dl.load", 3'd2, 8'hC3);
        chk("dl.load.retire_count", retire_count, 9);
        chk("dl.load.wb_ready", wb_ready, 1);
        step();
        mem_valid = 1'b0;
        chk_write("dl.alu", 3'd5, 8'h77);
        chk("dl.alu.retire_count", retire_count, 10);
        step();
        chk("dl.idle.RegWrite", RegWrite, 0);

        // Load timeout after 4 waiting cycles.
        drive(1, 0, 1, 3'd1, 2'b01, 8'h00, 8'h00, 0, 8'h00);
        step();
        mem_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("to.w%0d.wb_ready", c), wb_ready, 0);
            chk($sformatf("to.w%0d.load_err", c), load_err, 0);
            step();
        end
        chk("to.load_err", load_err, 1);
        chk("to.wb_ready", wb_ready, 1);
        chk("to.RegWrite", RegWrite, 0);
        chk("to.retire_count", retire_count, 10);
        load_valid = 1'b1; load_data = 8'h5C;
        step();
        load_valid = 1'b0;
        chk("to.late.RegWrite", RegWrite, 0);
        chk("to.late.retire_count", retire_count, 10);
        chk("to.sticky.load_err", load_err, 1);

        // Reset asserted while a load is pending.
        drive(1, 0, 1, 3'd3, 2'b01, 8'h00, 8'h00, 0, 8'h00);
        step();
        mem_valid = 1'b0;
        chk("rw.wait.wb_ready", wb_ready, 0);
        reset = 1'b1;
        #1;
        chk("rw.wb_ready", wb_ready, 1);
        chk("rw.load_err", load_err, 0);
        chk("rw.retire_count", retire_count, 0);
        chk("rw.outs", {RegWrite, write_reg, write_data, fwd_valid, fwd_rd, fwd_data}, 0);
        step();
        reset = 1'b0;
        load_valid = 1'b1; load_data = 8'hEE;
        step();
        load_valid = 1'b0;
        chk("rw.late.RegWrite", RegWrite, 0);
        chk("rw.late.retire_count", retire_count, 0);

        // Retire counter wrap: 65535 non-writing ops, then one more.
        drive(1, 0, 0, 3'd4, 2'b00, 8'h01, 8'h00, 0, 8'h00);
        repeat (65535) step();
        chk("wrap.ffff.retire_count", retire_count, 16'hFFFF);
        chk("wrap.ffff.RegWrite", RegWrite, 0);
        step();
        mem_valid = 1'b0;
        chk("wrap.zero.retire_count", retire_count, 16'h0000);
        step();
        chk("wrap.hold.retire_count", retire_count, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage of the 8-bit, 16-bit-instruction core. It accepts completed instructions from the memory stage and waits, with a bounded timeout, for load data from data memory. It drives the register-file write port (`RegWrite`, `write_reg`, `write_data`) consumed by the decode stage, and also provides forwarding information and a retired-instruction count.

## Interface

Parameters:
- `LOAD_TIMEOUT`, 15: maximum cycles spent in WAIT_LOAD before the load is abandoned; legal range 1–255.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `flush`  in  1  blocks acceptance of the current `mem_valid` entry.
- `mem_valid`  in  1  memory stage presents an instruction.
- `wb_ready`  out  1  stage can accept; combinational, equals `state == IDLE`.
- `mem_RegWrite`  in  1  instruction writes a register.
- `mem_rd`  in  3  destination register.
- `mem_ResultSrc`  in  2  00 ALU result, 01 load data, 10 `mem_pc_plus1`, 11 reserved (treated as 00).
- `mem_alu_result`  in  8  ALU result.
- `mem_pc_plus1`  in  8  link value.
- `load_valid`  in  1  data memory returns `load_data` this cycle.
- `load_data`  in  8  load return value.
- `RegWrite`  out  1  register-file write enable; one-cycle pulse per write.
- `write_reg`  out  3  register-file write address.
- `write_data`  out  8  register-file write data.
- `fwd_valid`  out  1  equals `RegWrite`; marks the forwarding bus valid for the hazard unit.
- `fwd_rd`  out  3  equals `write_reg`.
- `fwd_data`  out  8  equals `write_data`.
- `load_err`  out  1  sticky flag; set on load timeout.
- `retire_count`  out  16  count of retired instructions.

## Operation

- An entry is accepted when `mem_valid && wb_ready && !flush`. A flushed entry is dropped: no write, no retire.
- States:
  - IDLE: ready to accept.
  - WAIT_LOAD: holds the captured `mem_rd` and `mem_RegWrite`; a 8-bit timeout counter `tcnt` runs.
- Accepting a non-load (`ResultSrc != 01`):
  - Next cycle `RegWrite = mem_RegWrite && (mem_rd != 0)`.
  - `write_reg = mem_rd`; `write_data` is selected per `ResultSrc`.
  - The instruction retires.
  - State stays IDLE.
- Accepting a load with `load_valid` high in the same cycle: treated identically to a non-load, with `write_data = load_data`.
- Accepting a load with `load_valid` low: go to WAIT_LOAD and set `tcnt = 0`.
- In WAIT_LOAD, each cycle:
  - If `load_valid`: next cycle write the captured rd with `load_data`, under the same r0 and RegWrite gating; retire; return to IDLE.
  - Else if `tcnt == LOAD_TIMEOUT-1`: set `load_err`, make no write, do not retire, return to IDLE.
  - Else: increment `tcnt`.
- `flush` has no effect in WAIT_LOAD. The pending load belongs to an older, committed instruction.
- Writes to r0 are always suppressed. r0 still retires.
- Instructions with `mem_RegWrite = 0` (stores, branches) retire with no write.
- `retire_count` increments by 1 per retire and wraps from 0xFFFF to 0x0000.
- `load_err` clears only on reset.
- `load_valid` is ignored in IDLE unless a load is being accepted in that cycle.

## Timing

- Reset values: `RegWrite=0`, `write_reg=0`, `write_data=0`, `fwd_*=0`, `load_err=0`, `retire_count=0`, state IDLE. `wb_ready=1` after reset.
- Latency from acceptance (cycle N) of a non-load or same-cycle load to the `RegWrite` pulse: cycle N+1.
- For a delayed load whose `load_valid` arrives in cycle M: `RegWrite` pulses in cycle M+1, and `wb_ready` returns high in cycle M+1.
- `wb_ready` is low from cycle N+1 through the cycle in which `load_valid` or the timeout occurs.
- A timeout after L=`LOAD_TIMEOUT` waiting cycles: `load_err` rises and `wb_ready` returns high on cycle N+L+1.
- `RegWrite` is never high for two cycles from a single instruction.
- Back-to-back non-load acceptances give consecutive `RegWrite` pulses.
- `retire_count` updates on the same edge as the corresponding `RegWrite`.
- The register file writes on the edge ending the `RegWrite` cycle. Decode sees the value from the following cycle; `fwd_*` covers the gap.
- Reset asserted mid-WAIT_LOAD: immediate return to IDLE. The pending load is discarded with no write, and a later `load_valid` is ignored.

## Test plan

- Reset, then accept ALU op with rd=3, result=0x5A, RegWrite=1 → next cycle `RegWrite=1`, `write_reg=3`, `write_data=0x5A`, `retire_count=1`.
- Load to rd=2, `load_valid` 3 cycles after accept with data 0xC3 → `wb_ready` low for 3 cycles, then `RegWrite` pulse with `write_data=0xC3`; a `mem_valid` presented meanwhile is not accepted until `wb_ready` is high.
- Load with `LOAD_TIMEOUT=4` and `load_valid` never asserted → no write, `load_err=1`, `retire_count` unchanged, `wb_ready` high again after 4 waiting cycles.
- ALU op to rd=0 with value 0xFF, then a flushed op to rd=5 → no `RegWrite` for either; `retire_count` increments by 1 only.
- Preload `retire_count` to 0xFFFF by running 65535 non-writing ops, then one more → `retire_count=0x0000`; also assert `reset` during WAIT_LOAD → all outputs return to 0 and the late `load_valid` causes no write.
